// File: rtl/cdr_prbs_checker.sv
// rtl/cdr_prbs_checker.sv - self-synchronising PRBS-7 (x^7+x^6+1) checker with lock/BER counters
// Optional sticky loss-of-lock flag: define CDR_CHK_STICKY_LOL_EN.
module cdr_prbs_checker #(
   parameter int ERR_CNT_W = 16,
   parameter int BIT_CNT_W = 24,
   parameter int LOCK_GOOD = 32,
   parameter int WINDOW    = 64,
   parameter int LOSS_ERRS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bit_in,
   input  logic                 bit_valid,
   input  logic                 clr_cnt,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [BIT_CNT_W-1:0] bit_count,
   output logic [1:0]           state,
   output logic                 lol_sticky
);

   localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
   localparam int WIN_W  = $clog2(WINDOW);
   localparam int LERR_W = $clog2(LOSS_ERRS + 1);

   typedef enum logic [1:0] {
      ST_SEED   = 2'b00,
      ST_VERIFY = 2'b01,
      ST_LOCKED = 2'b10
   } state_t;

   state_t            st;
   logic [6:0]        lfsr;
   logic [2:0]        seed_cnt;
   logic [GOOD_W-1:0] good_cnt;
   logic [WIN_W-1:0]  win_cnt;
   logic [LERR_W-1:0] win_err;

   logic              pred;
   logic              mismatch;
   logic [6:0]        shifted_in;
   logic [LERR_W-1:0] win_err_next;
   logic              loss;

   assign state        = st;
   assign pred         = lfsr[6] ^ lfsr[5];
   assign mismatch     = bit_in != pred;
   assign shifted_in   = {lfsr[5:0], bit_in};
   assign win_err_next = win_err + LERR_W'(mismatch);
   assign loss         = bit_valid && (st == ST_LOCKED) && (win_err_next >= LERR_W'(LOSS_ERRS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= ST_SEED;
         lfsr      <= '0;
         seed_cnt  <= '0;
         good_cnt  <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
         bit_count <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (bit_valid) begin
            unique case (st)
               ST_SEED: begin
                  lfsr <= shifted_in;
                  if (seed_cnt == 3'd6) begin
                     st       <= ST_VERIFY;
                     seed_cnt <= '0;
                     good_cnt <= '0;
                  end else begin
                     seed_cnt <= seed_cnt + 3'd1;
                  end
               end
               ST_VERIFY: begin
                  lfsr <= shifted_in;
                  // an all-zero register is a PRBS fixed point and must never count as progress
                  if (!mismatch && (shifted_in != 7'd0)) begin
                     if (good_cnt == GOOD_W'(LOCK_GOOD - 1)) begin
                        st       <= ST_LOCKED;
                        locked   <= 1'b1;
                        good_cnt <= '0;
                        win_cnt  <= '0;
                        win_err  <= '0;
                     end else begin
                        good_cnt <= good_cnt + GOOD_W'(1);
                     end
                  end else begin
                     good_cnt <= '0;
                  end
               end
               ST_LOCKED: begin
                  // free-running reference so one flipped bit produces exactly one error
                  lfsr      <= {lfsr[5:0], pred};
                  err_pulse <= mismatch;
                  if (!(&bit_count))
                     bit_count <= bit_count + BIT_CNT_W'(1);
                  if (mismatch && !(&err_count))
                     err_count <= err_count + ERR_CNT_W'(1);
                  if (loss) begin
                     st       <= ST_SEED;
                     locked   <= 1'b0;
                     lfsr     <= '0;
                     seed_cnt <= '0;
                     good_cnt <= '0;
                     win_cnt  <= '0;
                     win_err  <= '0;
                  end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_cnt + WIN_W'(1);
                     win_err <= win_err_next;
                  end
               end
               default: st <= ST_SEED;
            endcase
         end
         if (clr_cnt) begin
            err_count <= '0;
            bit_count <= '0;
         end
      end
   end

`ifdef CDR_CHK_STICKY_LOL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lol_sticky <= 1'b0;
      else if (loss)
         lol_sticky <= 1'b1;
      else if (clr_cnt)
         lol_sticky <= 1'b0;
   end
`else
   assign lol_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_cdr_prbs_checker.sv
// tb/tb_cdr_prbs_checker.sv - randomized bench for cdr_prbs_checker with a queue-based reference model
`timescale 1ns/1ps
module tb_cdr_prbs_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       clr_cnt = 1'b0;
   logic       locked, err_pulse, lol_sticky;
   logic [3:0] err_count;
   logic [23:0] bit_count;
   logic [1:0] state;

   cdr_prbs_checker #(.ERR_CNT_W(4)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
      .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count),
      .state(state), .lol_sticky(lol_sticky)
   );

   always #5 clk = ~clk;

`ifdef CDR_CHK_STICKY_LOL_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: last seven reference bits kept as a queue, oldest first
   int         m_state, m_seed_n, m_good, m_wbits, m_werrs;
   bit         m_hist[$];
   logic [3:0] exp_err;
   logic [23:0] exp_bits;
   bit         exp_pulse, exp_sticky;

   task automatic model_reset();
      m_state = 0; m_seed_n = 0; m_good = 0; m_wbits = 0; m_werrs = 0;
      m_hist.delete();
      repeat (7) m_hist.push_back(1'b0);
      exp_err = '0; exp_bits = '0; exp_pulse = 0; exp_sticky = 0;
   endtask

   task automatic model_step(input bit b, input bit v, input bit c);
      bit p, lost;
      int ones;
      lost = 0;
      exp_pulse = 0;
      if (v) begin
         p = m_hist[0] ^ m_hist[1];
         if (m_state == 0) begin
            m_hist.push_back(b); void'(m_hist.pop_front());
            m_seed_n++;
            if (m_seed_n == 7) begin m_state = 1; m_good = 0; end
         end else if (m_state == 1) begin
            m_hist.push_back(b); void'(m_hist.pop_front());
            ones = 0;
            foreach (m_hist[i]) ones += m_hist[i];
            if (b == p && ones != 0) begin
               m_good++;
               if (m_good == 32) begin m_state = 2; m_wbits = 0; m_werrs = 0; end
            end else m_good = 0;
         end else begin
            m_hist.push_back(p); void'(m_hist.pop_front());
            if (exp_bits != 24'hFFFFFF) exp_bits++;
            if (b != p) begin
               exp_pulse = 1;
               m_werrs++;
               if (exp_err != 4'hF) exp_err++;
            end
            m_wbits++;
            if (m_werrs >= 8) begin
               lost = 1; m_state = 0; m_seed_n = 0; m_good = 0;
               m_hist.delete();
               repeat (7) m_hist.push_back(1'b0);
            end else if (m_wbits == 64) begin
               m_wbits = 0; m_werrs = 0;
            end
         end
      end
      if (c) begin exp_err = '0; exp_bits = '0; exp_sticky = 0; end
      if (lost && STICKY) exp_sticky = 1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("locked", locked, (m_state == 2));
         check("state", state, m_state);
         check("err_pulse", err_pulse, exp_pulse);
         check("err_count", err_count, exp_err);
         check("bit_count", bit_count, exp_bits);
         check("lol_sticky", lol_sticky, exp_sticky);
      end
   end

   logic [6:0] g = 7'h7F;

   task automatic gen_bit(output bit b);
      b = g[6] ^ g[5];
      g = {g[5:0], b};
   endtask

   task automatic tick(input bit b, input bit v, input bit c);
      bit_in = b; bit_valid = v; clr_cnt = c;
      @(posedge clk);
      #1;
      model_step(b, v, c);
   endtask

   task automatic send(input bit inv, input bit c, input int gap);
      bit b;
      gen_bit(b);
      tick(b ^ inv, 1'b1, c);
      for (int i = 0; i < gap; i++) tick(1'($urandom), 1'b0, 1'b0);
   endtask

   bit ever_locked;

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_locked", locked, 0);
      check("reset_state", state, 0);
      check("reset_err_count", err_count, 0);
      check("reset_bit_count", bit_count, 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // lock from seed 7F, one valid bit every 4 clocks
      for (int k = 1; k <= 39; k++) begin
         send(1'b0, 1'b0, 3);
         if (k == 38) check("not_locked_at_38", locked, 0);
      end
      check("locked_at_39", locked, 1);
      check("lock_err_count", err_count, 0);
      check("lock_bit_count", bit_count, 0);

      // eight errors inside the first window force loss of lock
      for (int k = 0; k < 22; k++) begin
         send((k % 3) == 0, 1'b0, 0);
         if (k == 0) check("first_locked_bit_count", bit_count, 1);
      end
      check("loss_locked", locked, 0);
      check("loss_state", state, 0);
      check("loss_err_count", err_count, 8);
      check("loss_sticky", lol_sticky, STICKY);

      for (int k = 1; k <= 39; k++) send(1'b0, 1'b0, 1);
      check("relock_39", locked, 1);
      check("relock_err_hold", err_count, 8);

      // single inverted bit
      repeat (5) send(1'b0, 1'b0, 0);
      send(1'b1, 1'b0, 0);
      check("single_err_pulse", err_pulse, 1);
      check("single_err_count", err_count, 9);
      send(1'b0, 1'b0, 0);
      check("single_err_pulse_drop", err_pulse, 0);
      repeat (70) send(1'b0, 1'b0, $urandom_range(0, 2));
      check("single_err_no_more", err_count, 9);
      check("single_err_still_locked", locked, 1);

      // isolated errors saturate the 4-bit counter
      for (int e = 0; e < 20; e++) begin
         repeat (69) send(1'b0, 1'b0, $urandom_range(0, 1));
         send(1'b1, 1'b0, 0);
      end
      check("sat_err_count", err_count, 15);
      check("sat_locked", locked, 1);
      repeat (3) send(1'b0, 1'b0, 0);
      send(1'b1, 1'b1, 0);
      check("clr_beats_inc", err_count, 0);
      check("clr_bit_count", bit_count, 0);

      // randomized traffic: sparse errors, random clears, a burst of raw noise
      for (int k = 0; k < 600; k++)
         send(($urandom % 40) == 0, ($urandom % 60) == 0, $urandom_range(0, 2));
      for (int k = 0; k < 150; k++) tick(1'($urandom), 1'($urandom), ($urandom % 50) == 0);
      repeat (80) send(1'b0, 1'b0, $urandom_range(0, 1));
      check("relock_after_random", locked, 1);

      // asynchronous reset between clock edges
      @(posedge clk);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check("async_locked", locked, 0);
      check("async_state", state, 0);
      check("async_err_pulse", err_pulse, 0);
      check("async_err_count", err_count, 0);
      check("async_bit_count", bit_count, 0);
      check("async_sticky", lol_sticky, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 1; k <= 39; k++) send(1'b0, 1'b0, 2);
      check("async_relock_39", locked, 1);

      // all-zero input must never lock
      ever_locked = 0;
      for (int k = 0; k < 500; k++) begin
         tick(1'b0, 1'b1, 1'b0);
         if (k >= 1 && locked && k > 40) ever_locked = 1;
      end
      check("allzero_no_lock", ever_locked, 0);
      check("allzero_state", state, 1);

      repeat (2) tick(1'b0, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
